// File: rtl/video_timing_pkg.sv
// Shared timing defaults, offset widths and clamp helper for the video timing generator.
package video_timing_pkg;

  localparam int H_ACTIVE_DEF = 336;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 24;
  localparam int H_BP_DEF     = 72;
  localparam int V_ACTIVE_DEF = 240;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 18;
  localparam int RGB_W_DEF    = 8;

  localparam int HOFFS_W = 5;
  localparam int VOFFS_W = 4;
  localparam int HPOS_W  = 10;
  localparam int VPOS_W  = 9;

  // Wide enough that 2*offset plus the largest nominal start never wraps.
  localparam int CALC_W = 12;
  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t clamp_calc(input calc_t v, input calc_t lo, input calc_t hi);
    calc_t r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Bundle of the generated timing and pixel outputs, with producer and consumer views.
interface video_timing_if #(
  parameter int RGB_W = video_timing_pkg::RGB_W_DEF
);
  logic [video_timing_pkg::HPOS_W-1:0] hpos;
  logic [video_timing_pkg::VPOS_W-1:0] vpos;
  logic                                hblank;
  logic                                vblank;
  logic                                hsync;
  logic                                vsync;
  logic                                de;
  logic [RGB_W-1:0]                    rgb_out;
  logic                                line_start;
  logic                                frame_start;

  modport master (
    output hpos, vpos, hblank, vblank, hsync, vsync, de, rgb_out, line_start, frame_start
  );

  modport slave (
    input hpos, vpos, hblank, vblank, hsync, vsync, de, rgb_out, line_start, frame_start
  );
endinterface

// File: rtl/video_axis_counter.sv
// One timing axis: wrapping position counter, blank flag and clamped sync-window compare.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int TOTAL  = 456,
  parameter int ACTIVE = 336,
  parameter int SYNC   = 24,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          step,
  input  calc_t         sync_nom,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          blank,
  output logic          in_sync
);

  logic [CW-1:0] cnt_q, cnt_d;
  calc_t         cnt_ext, sync_start, sync_end;

  assign last = (cnt_q == CW'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (ce && step) cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Keep the whole sync window inside the blanking region whatever the offset.
  assign cnt_ext    = calc_t'({{(CALC_W-CW){1'b0}}, cnt_q});
  assign sync_start = clamp_calc(sync_nom, calc_t'(ACTIVE), calc_t'(TOTAL - SYNC));
  assign sync_end   = sync_start + calc_t'(SYNC);

  assign cnt     = cnt_q;
  assign blank   = (cnt_q >= CW'(ACTIVE));
  assign in_sync = (cnt_ext >= sync_start) && (cnt_ext < sync_end);

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: h/v counters, offset-adjustable syncs, blanking and pixel gating.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int RGB_W    = RGB_W_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                      clk_sys,
  input  logic                      RESET_N,
  input  logic                      ce_pix,
  input  logic signed [HOFFS_W-1:0] hoffs,
  input  logic signed [VOFFS_W-1:0] voffs,
  input  logic [RGB_W-1:0]          rgb_in,
  output logic [HPOS_W-1:0]         hpos,
  output logic [VPOS_W-1:0]         vpos,
  output logic                      hblank,
  output logic                      vblank,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      line_start,
  output logic                      frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic signed [HOFFS_W-1:0] hoffs_q, hoffs_d;
  logic signed [VOFFS_W-1:0] voffs_q, voffs_d;
  logic                      hblank_q, hblank_d, vblank_q, vblank_d;
  logic                      hsync_q, hsync_d, vsync_q, vsync_d;
  logic                      de_q, de_d;
  logic [RGB_W-1:0]          rgb_q, rgb_d;
  logic                      line_start_q, line_start_d, frame_start_q, frame_start_d;

  logic  h_last, v_last, h_blank_now, v_blank_now, h_in_sync, v_in_sync, frame_origin;
  calc_t hoffs_ext, voffs_ext, h_nom, v_nom;

  assign hoffs_ext = calc_t'(hoffs_q);
  assign voffs_ext = calc_t'(voffs_q);
  assign h_nom     = calc_t'(H_ACTIVE + H_FP) + (hoffs_ext <<< 1);
  assign v_nom     = calc_t'(V_ACTIVE + V_FP) + voffs_ext;

  video_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC(H_SYNC), .CW(HPOS_W)
  ) u_h_axis (
    .clk(clk_sys), .rst_n(RESET_N), .ce(ce_pix), .step(1'b1), .sync_nom(h_nom),
    .cnt(hpos), .last(h_last), .blank(h_blank_now), .in_sync(h_in_sync)
  );

  // The vertical axis steps once per line, so vsync edges land on hcnt=0.
  video_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC(V_SYNC), .CW(VPOS_W)
  ) u_v_axis (
    .clk(clk_sys), .rst_n(RESET_N), .ce(ce_pix), .step(h_last), .sync_nom(v_nom),
    .cnt(vpos), .last(v_last), .blank(v_blank_now), .in_sync(v_in_sync)
  );

  assign frame_origin = (hpos == '0) && (vpos == '0);

  always_comb begin
    hoffs_d       = hoffs_q;
    voffs_d       = voffs_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    rgb_d         = rgb_q;
    // Strobes are re-evaluated every cycle so they stay one clk_sys wide.
    line_start_d  = ce_pix && h_last;
    frame_start_d = ce_pix && h_last && v_last;
    if (ce_pix) begin
      if (frame_origin) begin
        hoffs_d = hoffs;
        voffs_d = voffs;
      end
      hblank_d = h_blank_now;
      vblank_d = v_blank_now;
      hsync_d  = h_in_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d  = v_in_sync ? SYNC_POL : ~SYNC_POL;
      de_d     = ~(h_blank_now | v_blank_now);
      rgb_d    = (h_blank_now | v_blank_now) ? '0 : rgb_in;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      hoffs_q       <= '0;
      voffs_q       <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hoffs_q       <= hoffs_d;
      voffs_q       <= voffs_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb_out     = rgb_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default-timing instance for horizontal behaviour, short-line instance for frames.
`timescale 1ns/1ps
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: all defaults.
  logic              rst_a_n, ce_a;
  logic signed [4:0] hoffs_a;
  logic signed [3:0] voffs_a;
  logic [7:0]        rgb_a;
  video_timing_if #(.RGB_W(8)) vif_a();

  video_timing_gen dut_a (
    .clk_sys(clk), .RESET_N(rst_a_n), .ce_pix(ce_a), .hoffs(hoffs_a), .voffs(voffs_a),
    .rgb_in(rgb_a), .hpos(vif_a.hpos), .vpos(vif_a.vpos), .hblank(vif_a.hblank),
    .vblank(vif_a.vblank), .hsync(vif_a.hsync), .vsync(vif_a.vsync), .de(vif_a.de),
    .rgb_out(vif_a.rgb_out), .line_start(vif_a.line_start), .frame_start(vif_a.frame_start)
  );

  // Instance B: 32-pixel lines, default vertical timing, so whole frames stay short.
  logic              rst_b_n, ce_b;
  logic signed [4:0] hoffs_b;
  logic signed [3:0] voffs_b;
  logic [7:0]        rgb_b, rgb_out_b;
  logic [9:0]        hpos_b;
  logic [8:0]        vpos_b;
  logic              hblank_b, vblank_b, hsync_b, vsync_b, de_b, ls_b, fs_b;

  video_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(4), .H_BP(8)) dut_b (
    .clk_sys(clk), .RESET_N(rst_b_n), .ce_pix(ce_b), .hoffs(hoffs_b), .voffs(voffs_b),
    .rgb_in(rgb_b), .hpos(hpos_b), .vpos(vpos_b), .hblank(hblank_b), .vblank(vblank_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .rgb_out(rgb_out_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int m_hs_first, m_hs_cnt, m_hb_first, m_hb_cnt, m_ls_end, m_ls_extra, m_pix_bad;

  task automatic reset_a();
    rst_a_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a_n = 1'b1;
  endtask

  task automatic wait_line_a();
    int n;
    n = 0;
    while (vif_a.line_start !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) check_val("line_start_wait", 0, 1);
  endtask

  // Measures one full line; iteration i sees outputs belonging to delayed hcnt = i.
  task automatic measure_line_a();
    logic [7:0] px;
    m_hs_first = -1; m_hs_cnt = 0; m_hb_first = -1; m_hb_cnt = 0;
    m_ls_end = 0; m_ls_extra = 0; m_pix_bad = 0;
    wait_line_a();
    for (int i = 0; i < 456; i++) begin
      px = 8'(i * 7 + 3);
      rgb_a = px;
      @(posedge clk);
      #1;
      if (vif_a.hsync == 1'b0) begin
        if (m_hs_first < 0) m_hs_first = i;
        m_hs_cnt++;
      end
      if (vif_a.hblank) begin
        if (m_hb_first < 0) m_hb_first = i;
        m_hb_cnt++;
      end
      if (vif_a.de != !(vif_a.hblank | vif_a.vblank)) m_pix_bad++;
      if (vif_a.rgb_out != ((vif_a.hblank | vif_a.vblank) ? 8'h00 : px)) m_pix_bad++;
      if (vif_a.line_start) begin
        if (i == 455) m_ls_end = 1;
        else m_ls_extra++;
      end
    end
  endtask

  initial begin
    int n, t0, t1, npulse, hold_bad, ls_wide, ls_prev;
    logic [43:0] snap;
    int ph, pv, f, nfs, misalign, vb_first;
    int vs_first[3], vs_last[3], fs_t[3];
    logic prev_vs;

    rst_a_n = 1'b0; ce_a = 1'b1; hoffs_a = '0; voffs_a = '0; rgb_a = '0;
    rst_b_n = 1'b0; ce_b = 1'b1; hoffs_b = '0; voffs_b = '0; rgb_b = 8'h11;

    // Reset state while ce_pix is running.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hpos", int'(vif_a.hpos), 0);
    check_val("rst_vpos", int'(vif_a.vpos), 0);
    check_val("rst_hblank", int'(vif_a.hblank), 1);
    check_val("rst_vblank", int'(vif_a.vblank), 1);
    check_val("rst_hsync", int'(vif_a.hsync), 1);
    check_val("rst_vsync", int'(vif_a.vsync), 1);
    check_val("rst_de", int'(vif_a.de), 0);
    check_val("rst_rgb", int'(vif_a.rgb_out), 0);
    check_val("rst_line_start", int'(vif_a.line_start), 0);
    check_val("rst_frame_start", int'(vif_a.frame_start), 0);

    // First tick after release: counters at 0/0, outputs describe pixel (0,0).
    rgb_a = 8'h5a;
    rst_a_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("tick1_hpos", int'(vif_a.hpos), 1);
    check_val("tick1_hblank", int'(vif_a.hblank), 0);
    check_val("tick1_vblank", int'(vif_a.vblank), 0);
    check_val("tick1_de", int'(vif_a.de), 1);
    check_val("tick1_rgb", int'(vif_a.rgb_out), 'h5a);

    // hoffs = 0: sync 360..383, blank 336..455, period 456.
    measure_line_a();
    check_val("h0_hs_start", m_hs_first, 360);
    check_val("h0_hs_width", m_hs_cnt, 24);
    check_val("h0_hb_start", m_hb_first, 336);
    check_val("h0_hb_width", m_hb_cnt, 120);
    check_val("h0_ls_period", m_ls_end, 1);
    check_val("h0_ls_extra", m_ls_extra, 0);
    check_val("h0_pixel_errs", m_pix_bad, 0);

    // hoffs = +15 latched at frame origin: start 390; a mid-frame change is ignored.
    hoffs_a = 5'sd15;
    reset_a();
    measure_line_a();
    check_val("hp15_hs_start", m_hs_first, 390);
    check_val("hp15_hs_width", m_hs_cnt, 24);
    hoffs_a = 5'sd0;
    measure_line_a();
    check_val("hp15_midframe_hs_start", m_hs_first, 390);

    // hoffs = -16: nominal 328 clamps to 336.
    hoffs_a = -5'sd16;
    reset_a();
    measure_line_a();
    check_val("hm16_hs_start", m_hs_first, 336);
    check_val("hm16_hs_width", m_hs_cnt, 24);

    // Asynchronous reset in the middle of hsync.
    hoffs_a = 5'sd0;
    reset_a();
    n = 0;
    while (vif_a.hpos != 10'd370 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) check_val("hpos370_wait", 0, 1);
    check_val("midrst_hsync_before", int'(vif_a.hsync), 0);
    #2;
    rst_a_n = 1'b0;
    #1;
    check_val("midrst_hsync", int'(vif_a.hsync), 1);
    check_val("midrst_hpos", int'(vif_a.hpos), 0);
    check_val("midrst_hblank", int'(vif_a.hblank), 1);
    check_val("midrst_de", int'(vif_a.de), 0);
    check_val("midrst_rgb", int'(vif_a.rgb_out), 0);
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    n = 0;
    while (vif_a.line_start !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("midrst_first_line_ticks", n, 456);

    // ce_pix every third cycle: outputs hold between ticks, line period 1368 cycles.
    ce_a = 1'b0;
    reset_a();
    t0 = -1; t1 = -1; npulse = 0; hold_bad = 0; ls_wide = 0; ls_prev = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ce_a = (cyc % 3 == 2);
      rgb_a = 8'($urandom);
      snap = {vif_a.hpos, vif_a.vpos, vif_a.hblank, vif_a.vblank, vif_a.hsync,
              vif_a.vsync, vif_a.de, vif_a.rgb_out, 8'h00};
      @(posedge clk);
      #1;
      if (!ce_a && snap != {vif_a.hpos, vif_a.vpos, vif_a.hblank, vif_a.vblank, vif_a.hsync,
                            vif_a.vsync, vif_a.de, vif_a.rgb_out, 8'h00}) hold_bad++;
      if (vif_a.line_start) begin
        if (ls_prev != 0) ls_wide++;
        if (npulse == 0) t0 = cyc;
        else if (npulse == 1) t1 = cyc;
        npulse++;
      end
      ls_prev = int'(vif_a.line_start);
    end
    ce_a = 1'b1;
    check_val("ce3_hold_errs", hold_bad, 0);
    check_val("ce3_ls_pulses", npulse, 2);
    check_val("ce3_line_period", t1 - t0, 1368);
    check_val("ce3_ls_wide", ls_wide, 0);

    // Instance B: vsync placement across two frames, voffs changed mid frame 0.
    rst_b_n = 1'b1;
    ph = int'(hpos_b); pv = int'(vpos_b);
    f = 0; nfs = 0; misalign = 0; vb_first = -1; prev_vs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vs_first[k] = -1; vs_last[k] = -1; fs_t[k] = -1;
    end
    for (int cyc = 0; cyc < 16800; cyc++) begin
      if (cyc == 3200) voffs_b = 4'sd3;
      @(posedge clk);
      #1;
      if (vsync_b == 1'b0) begin
        if (vs_first[f] < 0) vs_first[f] = pv;
        vs_last[f] = pv;
      end
      if (vsync_b != prev_vs && ph != 0) misalign++;
      if (f == 0 && vblank_b && vb_first < 0) vb_first = pv;
      if (fs_b) begin
        if (nfs < 3) fs_t[nfs] = cyc;
        nfs++;
        if (f < 2) f++;
      end
      prev_vs = vsync_b;
      ph = int'(hpos_b);
      pv = int'(vpos_b);
    end
    check_val("f0_vs_first", vs_first[0], 241);
    check_val("f0_vs_last", vs_last[0], 243);
    check_val("f1_vs_first", vs_first[1], 244);
    check_val("f1_vs_last", vs_last[1], 246);
    check_val("vs_edge_misalign", misalign, 0);
    check_val("vblank_first_line", vb_first, 240);
    check_val("fs_count", nfs, 2);
    check_val("fs_first_cycle", fs_t[0], 8383);
    check_val("frame_period_cycles", fs_t[1] - fs_t[0], 8384);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
